// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and types for the two-master arbiter.
//   HTRANS_* / HBURST_SINGLE : bus encodings
//   owner_t                  : which master owns an address or data phase
//   addr_ph_t                : one complete address-phase payload
package ahbl_pkg;

  localparam int unsigned ADDR_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
  } addr_ph_t;

endpackage

// File: rtl/ahbl_addr_hold.sv
// Single-entry holding register for an address phase that lost arbitration.
//   HCLK, HRESETn : clock, async active-low reset
//   live_ph       : the master's current address-phase signals
//   capture       : load live_ph and mark the entry valid
//   clear         : the held transfer was accepted on the shared bus
//   pend_ph       : held address phase
//   pend_valid    : entry holds a transfer not yet issued
module ahbl_addr_hold
  import ahbl_pkg::*;
(
  input  logic     HCLK,
  input  logic     HRESETn,
  input  addr_ph_t live_ph,
  input  logic     capture,
  input  logic     clear,
  output addr_ph_t pend_ph,
  output logic     pend_valid
);

  // Capture and clear never coincide for the same master; clear wins anyway.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_ph    <= '0;
      pend_valid <= 1'b0;
    end else if (clear) begin
      pend_valid <= 1'b0;
    end else if (capture) begin
      pend_ph    <= live_ph;
      pend_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/ahbl_arbiter_2.sv
// Two-master AHB-Lite arbiter sharing one downstream AHB-Lite bus.
// Every master address phase is accepted; a loser is parked in its holding
// register and its data phase is stalled until the parked transfer completes.
//   HCLK, HRESETn         : clock, async active-low reset
//   Mx_H* (x=0,1)         : master address/write-data inputs
//   Mx_HREADY, Mx_HRDATA  : per-master ready and read data
//   HADDR..HWDATA         : shared-bus outputs
//   HREADY, HRDATA        : shared-bus ready and read data
//   RR                    : 1 = round-robin, 0 = fixed priority (M0 wins)
module ahbl_arbiter_2
  import ahbl_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  addr_ph_t live0, live1, pend0, pend1, bus;
  logic     pv0, pv1;
  logic     live_req0, live_req1, req0, req1;
  logic     cap0, cap1, clr0, clr1, accept;
  logic     hold_q, holder_cont;
  owner_t   arb_win, addr_own, addr_own_q, data_own_q, last_grant_q, hold_own_q;

  assign live0 = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT};
  assign live1 = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT};

  // Master ready: shared HREADY while in our data phase, stalled while parked.
  assign M0_HREADY = (data_own_q == OWN_M0) ? HREADY : ~pv0;
  assign M1_HREADY = (data_own_q == OWN_M1) ? HREADY : ~pv1;
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

  assign live_req0 = M0_HTRANS[1] & M0_HREADY;
  assign live_req1 = M1_HTRANS[1] & M1_HREADY;
  assign req0      = pv0 | live_req0;
  assign req1      = pv1 | live_req1;

  // Burst holder keeps the bus while it issues SEQ or BUSY (both have bit 0 set).
  always_comb begin
    holder_cont = 1'b0;
    case (hold_own_q)
      OWN_M0:  holder_cont = hold_q & M0_HTRANS[0];
      OWN_M1:  holder_cont = hold_q & M1_HTRANS[0];
      default: holder_cont = 1'b0;
    endcase
  end

  // Arbitration among current requesters.
  always_comb begin
    arb_win = OWN_NONE;
    if (holder_cont) begin
      arb_win = hold_own_q;
    end else if (req0 && req1) begin
      arb_win = (RR && (last_grant_q == OWN_M0)) ? OWN_M1 : OWN_M0;
    end else if (req0) begin
      arb_win = OWN_M0;
    end else if (req1) begin
      arb_win = OWN_M1;
    end
  end

  // Owner only changes on HREADY so a stalled address phase stays stable.
  always_comb begin
    addr_own = addr_own_q;
    if (!HRESETn) begin
      addr_own = OWN_NONE;
    end else if (HREADY) begin
      addr_own = arb_win;
    end
  end

  // Shared address mux: parked entry takes precedence over live signals.
  always_comb begin
    bus = '0;
    case (addr_own)
      OWN_M0:  bus = pv0 ? pend0 : live0;
      OWN_M1:  bus = pv1 ? pend1 : live1;
      default: bus = '0;
    endcase
  end

  assign {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT} = bus;

  assign accept = HREADY & (addr_own != OWN_NONE) & bus.htrans[1];
  assign cap0   = live_req0 & ((addr_own != OWN_M0) | ~HREADY);
  assign cap1   = live_req1 & ((addr_own != OWN_M1) | ~HREADY);
  assign clr0   = accept & (addr_own == OWN_M0);
  assign clr1   = accept & (addr_own == OWN_M1);

  ahbl_addr_hold u_hold0 (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .live_ph    (live0),
    .capture    (cap0),
    .clear      (clr0),
    .pend_ph    (pend0),
    .pend_valid (pv0)
  );

  ahbl_addr_hold u_hold1 (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .live_ph    (live1),
    .capture    (cap1),
    .clear      (clr1),
    .pend_ph    (pend1),
    .pend_valid (pv1)
  );

  // Write data follows the data-phase owner.
  always_comb begin
    HWDATA = '0;
    case (data_own_q)
      OWN_M0:  HWDATA = M0_HWDATA;
      OWN_M1:  HWDATA = M1_HWDATA;
      default: HWDATA = '0;
    endcase
  end

  // Ownership, fairness and burst-hold state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_own_q   <= OWN_NONE;
      data_own_q   <= OWN_NONE;
      last_grant_q <= OWN_M1;
      hold_q       <= 1'b0;
      hold_own_q   <= OWN_NONE;
    end else begin
      addr_own_q <= addr_own;
      if (HREADY) begin
        if (accept) begin
          data_own_q   <= addr_own;
          last_grant_q <= addr_own;
          hold_q       <= (bus.hburst != HBURST_SINGLE);
          hold_own_q   <= addr_own;
        end else begin
          data_own_q <= OWN_NONE;
          hold_q     <= holder_cont;
        end
      end
    end
  end

endmodule
